// File: rtl/freq_select_if.sv
// Button inputs and divider-factor outputs of the frequency selector.
// master = stimulus/button side, slave = freq_select itself.
interface freq_select_if;
    logic        btn_up;
    logic        btn_down;
    logic [31:0] div_factor;
    logic [2:0]  level;
    logic        changed;

    modport master (
        output btn_up,
        output btn_down,
        input  div_factor,
        input  level,
        input  changed
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output div_factor,
        output level,
        output changed
    );
endinterface

// File: rtl/freq_select.sv
// Turns faster/slower push-buttons into a saturating speed level and the
// matching registered division factor for the clock divider.
module freq_select #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEFAULT_LEVEL   = 0
) (
    input  logic          clk_in,
    input  logic          rst_,
    freq_select_if.slave  bus
);

    localparam int               CNT_W       = ($clog2(DEBOUNCE_CYCLES) > 20) ?
                                               $clog2(DEBOUNCE_CYCLES) : 20;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       LEVEL_MAX   = 3'd7;
    localparam logic [2:0]       LEVEL_MIN   = 3'd0;
    localparam logic [2:0]       RESET_LEVEL = 3'(DEFAULT_LEVEL);

    function automatic logic [31:0] factor_of(input logic [2:0] lvl);
        logic [31:0] f;
        case (lvl)
            3'd0:    f = 32'd50000000;
            3'd1:    f = 32'd25000000;
            3'd2:    f = 32'd10000000;
            3'd3:    f = 32'd5000000;
            3'd4:    f = 32'd2500000;
            3'd5:    f = 32'd1000000;
            3'd6:    f = 32'd500000;
            default: f = 32'd50000;
        endcase
        return f;
    endfunction

    // Bit 0 carries the up button, bit 1 the down button, through every stage.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];

    logic [2:0]  level_q;
    logic [2:0]  level_next;
    logic [31:0] factor_q;
    logic        changed_q;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    always_ff @(posedge clk_in or negedge rst_) begin
        if (!rst_) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // Accept a new level only after it differs from stable for DEBOUNCE_CYCLES cycles.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Simultaneous presses cancel; saturated presses leave the level alone.
    always_comb begin
        level_next = level_q;
        case (press)
            2'b01:   if (level_q != LEVEL_MAX) level_next = level_q + 3'd1;
            2'b10:   if (level_q != LEVEL_MIN) level_next = level_q - 3'd1;
            default: level_next = level_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_) begin
        if (!rst_) begin
            level_q   <= RESET_LEVEL;
            factor_q  <= factor_of(RESET_LEVEL);
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (level_next != level_q) begin
                level_q   <= level_next;
                factor_q  <= factor_of(level_next);
                changed_q <= 1'b1;
            end
        end
    end

    assign bus.level      = level_q;
    assign bus.div_factor = factor_q;
    assign bus.changed    = changed_q;

endmodule

// File: tb/tb_freq_select.sv
// Self-checking bench for freq_select: scoreboard of expected {level, factor}
// pairs, pushed when a press is driven and popped on each changed pulse.
module tb_freq_select;

    localparam int DEB = 4;

    logic clk_in;
    logic rst_;
    freq_select_if bus ();

    freq_select #(
        .DEBOUNCE_CYCLES(DEB),
        .DEFAULT_LEVEL  (0)
    ) dut (
        .clk_in(clk_in),
        .rst_  (rst_),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [34:0] exp_q[$];
    int          m_level = 0;
    logic [2:0]  cur_level  = 3'd0;
    logic [31:0] cur_factor = 32'd50000000;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] tbl(input int lvl);
        logic [31:0] f;
        case (lvl)
            0:       f = 32'd50000000;
            1:       f = 32'd25000000;
            2:       f = 32'd10000000;
            3:       f = 32'd5000000;
            4:       f = 32'd2500000;
            5:       f = 32'd1000000;
            6:       f = 32'd500000;
            default: f = 32'd50000;
        endcase
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_level(input int lvl);
        exp_q.push_back({3'(lvl), tbl(lvl)});
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        check("q_empty_at_reset", 64'(exp_q.size()), 64'd0);
        m_level = 0;
        cycles(3);
        rst_ = 1'b1;
        cycles(2);
    endtask

    // One clean press held well past the debounce window, then a long release.
    task automatic press(input bit up);
        if (up) bus.btn_up = 1'b1;
        else    bus.btn_down = 1'b1;
        if (up && m_level < 7) begin
            m_level++;
            push_level(m_level);
        end else if (!up && m_level > 0) begin
            m_level--;
            push_level(m_level);
        end
        cycles(DEB + 8);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cycles(DEB + 8);
    endtask

    // Every cycle: changed must match a scoreboard entry, otherwise outputs hold.
    always @(negedge clk_in) begin
        if (!rst_) begin
            cur_level  = 3'd0;
            cur_factor = 32'd50000000;
            check("rst_changed", 64'(bus.changed), 64'd0);
        end else if (bus.changed) begin
            if (exp_q.size() == 0) begin
                check("changed_unexp", 64'(bus.changed), 64'd0);
            end else begin
                logic [34:0] item;
                item = exp_q.pop_front();
                check("sb_level", 64'(bus.level), 64'(item[34:32]));
                check("sb_factor", 64'(bus.div_factor), 64'(item[31:0]));
                cur_level  = item[34:32];
                cur_factor = item[31:0];
            end
        end else begin
            check("hold_level", 64'(bus.level), 64'(cur_level));
            check("hold_factor", 64'(bus.div_factor), 64'(cur_factor));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_         = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        #1 rst_ = 1'b0;
        #1;
        check("reset_factor", 64'(bus.div_factor), 64'd50000000);
        check("reset_level", 64'(bus.level), 64'd0);
        check("reset_changed", 64'(bus.changed), 64'd0);
        cycles(3);
        rst_ = 1'b1;
        cycles(3);

        // Held press: step exactly at edge DEB+3 after the first sampling edge.
        bus.btn_up = 1'b1;
        m_level = 1;
        push_level(1);
        for (int k = 0; k <= DEB + 4; k++) begin
            @(negedge clk_in);
            check("latency_changed", 64'(bus.changed), 64'(k == DEB + 3));
        end
        check("latency_level", 64'(bus.level), 64'd1);
        check("latency_factor", 64'(bus.div_factor), 64'd25000000);
        cycles(20);
        bus.btn_up = 1'b0;
        cycles(DEB + 8);
        check("hold_no_repeat", 64'(bus.level), 64'd1);

        // Short glitches below the debounce window are rejected.
        for (int w = 1; w <= 3; w++) begin
            bus.btn_up = 1'b1;
            cycles(w);
            bus.btn_up = 1'b0;
            cycles(15);
        end
        check("glitch_level", 64'(bus.level), 64'd1);

        // Saturate at level 7, then step down once.
        do_reset();
        for (int p = 0; p < 8; p++) press(1'b1);
        check("sat_level", 64'(bus.level), 64'd7);
        check("sat_factor", 64'(bus.div_factor), 64'd50000);
        press(1'b0);
        check("down_level", 64'(bus.level), 64'd6);
        check("down_factor", 64'(bus.div_factor), 64'd500000);

        // Simultaneous up and down from level 3 cancel.
        do_reset();
        for (int p = 0; p < 3; p++) press(1'b1);
        check("pre_both_level", 64'(bus.level), 64'd3);
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        cycles(DEB + 10);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cycles(DEB + 10);
        check("both_level", 64'(bus.level), 64'd3);
        check("both_factor", 64'(bus.div_factor), 64'd5000000);

        // Reset mid-debounce discards the partial count; held button re-debounces.
        do_reset();
        bus.btn_up = 1'b1;
        cycles(4);
        rst_ = 1'b0;
        cycles(3);
        check("midrst_level", 64'(bus.level), 64'd0);
        rst_ = 1'b1;
        m_level = 1;
        push_level(1);
        for (int k = 0; k <= DEB + 4; k++) begin
            @(negedge clk_in);
            check("midrst_changed", 64'(bus.changed), 64'(k == DEB + 3));
        end
        check("midrst_step_level", 64'(bus.level), 64'd1);
        bus.btn_up = 1'b0;
        cycles(DEB + 8);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_select.md
Name: freq_select

Overview:
- Upstream control stage for the programmable clock divider.
- Turns two raw push-buttons (faster/slower) into the 32-bit division factor the divider consumes. Buttons are synchronised, debounced and edge-detected.
- A saturating speed level indexes a fixed table of factors. The registered factor and a one-cycle change strobe are driven straight into the divider's div_factor input.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range >= 2.
- DEFAULT_LEVEL, 0, level loaded on reset; legal range 0..7.

Ports:
- clk_in  input  1  system clock, the same clock that feeds the divider.
- rst_  input  1  asynchronous active-low reset.
- btn_up  input  1  raw active-high button, asynchronous to clk_in; requests a faster output (smaller factor).
- btn_down  input  1  raw active-high button, asynchronous to clk_in; requests a slower output (larger factor).
- div_factor  output  32  registered division factor for the divider.
- level  output  3  current speed level, 0 = slowest, 7 = fastest.
- changed  output  1  one-cycle pulse in the cycle div_factor takes a new value.

Behaviour:
- One clock (clk_in); reset rst_ is asynchronous, active-low. All flops clear/preset on negedge rst_, with no dependence on clk_in.
- Reset values:
  - level = DEFAULT_LEVEL; div_factor = TABLE[DEFAULT_LEVEL]; changed = 0.
  - Synchroniser flops, debounced states, debounce counters and press pulses all = 0.
- Factor table (fixed, all nonzero; output freq = f_clk/(2*factor)):
  - L0 50000000, L1 25000000, L2 10000000, L3 5000000.
  - L4 2500000, L5 1000000, L6 500000, L7 50000.
- Per button, identical logic:
  - Synchroniser: 2-flop, giving s2.
  - Debounce counter: 20+ bits, wide enough for DEBOUNCE_CYCLES-1.
    - If s2 == stable, counter clears.
    - Otherwise counter increments. When it equals DEBOUNCE_CYCLES-1 while s2 != stable, stable <= s2 and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Press pulse: registered, 1 cycle, asserted the cycle after stable goes 0->1. Release (1->0) produces no pulse.
- Level update, on the cycle after a press pulse:
  - up pulse only: level = min(level+1, 7).
  - down pulse only: level = max(level-1, 0).
  - Both pulses in the same cycle: no change, changed stays 0.
  - div_factor = TABLE[new level], registered in the same edge as level.
  - changed = 1 for exactly that cycle, only if the level actually changed. Saturated presses give no pulse and no div_factor change.
- Latency: raw edge held stable -> div_factor/level/changed update at clock edge DEBOUNCE_CYCLES+3 after the first sampling edge.
  - 2 cycles synchroniser, DEBOUNCE_CYCLES debounce, 1 cycle pulse, 1 cycle update.
- Holding a button gives exactly one step; no auto-repeat.
- Reset mid-operation: any partial debounce count is discarded. A button held through reset release is treated as a fresh press: after full debounce it steps the level once.
- div_factor never changes except on a changed pulse. Downstream may use changed to restart its counter so that a shrinking factor does not cause a long wrap.

Test Plan:
- Reset, DEFAULT_LEVEL=0, DEBOUNCE_CYCLES=4 -> div_factor=50000000, level=0, changed=0, checked immediately on rst_ low with no clock edge.
- btn_up held high from cycle 0 -> at edge 7: level=1, div_factor=25000000, changed=1 for one cycle. Continued holding produces no further step.
- btn_up pulses of 1, 2 and 3 cycles separated by long lows -> no level change, changed never asserted.
- 8 clean btn_up presses from level 0 -> level saturates at 7, div_factor=50000. The 8th press gives changed=0. Then one btn_down -> level=6, div_factor=500000, changed=1.
- btn_up and btn_down rising in the same cycle from level 3 -> level stays 3, div_factor stays 5000000, changed=0.
- btn_up held, rst_ asserted at debounce count 2 then released -> no step before release. The step to level 1 occurs DEBOUNCE_CYCLES+3 edges after release.
